// File: rtl/ddr_ser_pkg.sv
// Shared types and elaboration helpers for the DDR output serializer.
// Holds the pair struct, the remaining-pairs counter width and the legality check.
package ddr_ser_pkg;

   // One output pair: h leaves while clk is high, l while clk is low.
   typedef struct packed {
      logic h;
      logic l;
   } pair_t;

   function automatic int cnt_width(input int ser_w);
      int w;
      w = $clog2(ser_w / 2 + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit params_ok(input int ch, input int ser_w);
      return (ch >= 1) && (ser_w >= 2) && ((ser_w % 2) == 0);
   endfunction

endpackage

// File: rtl/ddr_cell.sv
// One DDR output pin: a registered pair feeding a clock-muxed output.
// Behavioural stand-in for the vendor DDR primitive; reset maps to its aclr/aset.
module ddr_cell
   import ddr_ser_pkg::*;
#(
   parameter logic IDLE = 1'b0
) (
   input  logic  clk_i,
   input  logic  rst_n_i,
   input  pair_t pair_i,
   output logic  ddr_o
);

   logic h_r;
   logic l_r;

   // Asynchronous clear/preset forces the pin to IDLE mid-half-cycle on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h_r <= IDLE;
         l_r <= IDLE;
      end else begin
         h_r <= pair_i.h;
         l_r <= pair_i.l;
      end
   end

   assign ddr_o = clk_i ? h_r : l_r;

endmodule

// File: rtl/ddr_ser_out.sv
// Multi-channel DDR output serializer: one word per channel in, two bits per clock out.
// Channels shift in lockstep; the last pair and the next load share an edge.
module ddr_ser_out
   import ddr_ser_pkg::*;
#(
   parameter int   CH        = 1,
   parameter int   SER_W     = 8,
   parameter bit   MSB_FIRST = 1'b0,
   parameter logic IDLE      = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [CH*SER_W-1:0] data_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic                busy_o,
   output logic [CH-1:0]       ddr_o
);

   localparam int               CNT_W    = cnt_width(SER_W);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SER_W / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (!params_ok(CH, SER_W)) begin : g_param_check
      $fatal(1, "ddr_ser_out: SER_W must be even and >= 2, CH must be >= 1");
   end

   logic             run_r;
   logic [CNT_W-1:0] cnt_r;
   logic [SER_W-1:0] sh_r     [CH];
   pair_t            pair_r   [CH];
   logic [SER_W-1:0] sh_adv   [CH];
   pair_t            pair_nxt [CH];
   logic             accept;

   // Handshake: a word transfers on a clock edge where valid_i & ready_o; ready_o
   // depends on registers only, and the upstream holds data_i stable until then.
   assign ready_o = run_r & (cnt_r <= CNT_ONE);
   assign busy_o  = (cnt_r != '0);
   assign accept  = valid_i & ready_o;

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         if (MSB_FIRST) begin
            pair_nxt[c] = '{h: sh_r[c][SER_W-1], l: sh_r[c][SER_W-2]};
            sh_adv[c]   = sh_r[c] << 2;
         end else begin
            pair_nxt[c] = '{h: sh_r[c][0], l: sh_r[c][1]};
            sh_adv[c]   = sh_r[c] >> 2;
         end
      end
   end

   // A load on the last-pair edge still emits that pair, so streaming is gapless.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         run_r <= 1'b0;
         cnt_r <= '0;
         for (int c = 0; c < CH; c++) begin
            sh_r[c]   <= '0;
            pair_r[c] <= '{h: IDLE, l: IDLE};
         end
      end else begin
         run_r <= 1'b1;
         for (int c = 0; c < CH; c++) begin
            pair_r[c] <= busy_o ? pair_nxt[c] : '{h: IDLE, l: IDLE};
            if (accept) begin
               sh_r[c] <= data_i[c*SER_W +: SER_W];
            end else if (busy_o) begin
               sh_r[c] <= sh_adv[c];
            end
         end
         if (accept) begin
            cnt_r <= CNT_LOAD;
         end else if (busy_o) begin
            cnt_r <= cnt_r - CNT_ONE;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_cell
      ddr_cell #(
         .IDLE (IDLE)
      ) u_cell (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .pair_i  (pair_r[c]),
         .ddr_o   (ddr_o[c])
      );
   end

endmodule

// File: tb/tb_ddr_ser_out.sv
// Directed bench for ddr_ser_out: four configurations sharing one clock.
// Pins are sampled mid high-half (h) and mid low-half (l) against hand-written sequences.
module tb_ddr_ser_out;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic rst_n   = 1'b1;
   logic rst_n_d = 1'b1;

   // A: CH=2, SER_W=8, LSB-first, IDLE=0
   logic [15:0] data_a;
   logic        valid_a, ready_a, busy_a;
   logic [1:0]  ddr_a;
   // B: CH=1, SER_W=4, MSB-first, IDLE=0
   logic [3:0]  data_b;
   logic        valid_b, ready_b, busy_b;
   logic [0:0]  ddr_b;
   // C: CH=1, SER_W=2, LSB-first, IDLE=0
   logic [1:0]  data_c;
   logic        valid_c, ready_c, busy_c;
   logic [0:0]  ddr_c;
   // D: CH=1, SER_W=8, LSB-first, IDLE=1, own reset
   logic [7:0]  data_d;
   logic        valid_d, ready_d, busy_d;
   logic [0:0]  ddr_d;

   // Expected half-cycle sequences, written left to right in pin order.
   logic [0:7]  sw0 = 8'b1010_0101;
   logic [0:7]  sw1 = 8'b0011_1100;
   logic [0:15] bb0 = 16'b1000_0000_0000_0001;
   logic [0:15] bb1 = 16'b0000_1111_1111_0000;
   logic [0:10] bb_rdy = 11'b000_1000_1111;
   logic [0:3]  ms  = 4'b1000;
   logic [0:5]  w2  = 6'b10_01_11;
   logic [0:7]  rs  = 8'b0110_1001;

   ddr_ser_out #(.CH(2), .SER_W(8), .MSB_FIRST(1'b0), .IDLE(1'b0)) u_a (
      .clk_i (clk), .rst_n_i (rst_n), .data_i (data_a), .valid_i (valid_a),
      .ready_o (ready_a), .busy_o (busy_a), .ddr_o (ddr_a));
   ddr_ser_out #(.CH(1), .SER_W(4), .MSB_FIRST(1'b1), .IDLE(1'b0)) u_b (
      .clk_i (clk), .rst_n_i (rst_n), .data_i (data_b), .valid_i (valid_b),
      .ready_o (ready_b), .busy_o (busy_b), .ddr_o (ddr_b));
   ddr_ser_out #(.CH(1), .SER_W(2), .MSB_FIRST(1'b0), .IDLE(1'b0)) u_c (
      .clk_i (clk), .rst_n_i (rst_n), .data_i (data_c), .valid_i (valid_c),
      .ready_o (ready_c), .busy_o (busy_c), .ddr_o (ddr_c));
   ddr_ser_out #(.CH(1), .SER_W(8), .MSB_FIRST(1'b0), .IDLE(1'b1)) u_d (
      .clk_i (clk), .rst_n_i (rst_n_d), .data_i (data_d), .valid_i (valid_d),
      .ready_o (ready_d), .busy_o (busy_d), .ddr_o (ddr_d));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic to_high();
      @(posedge clk);
      #2;
   endtask

   task automatic to_low();
      @(negedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      data_a = 16'hFFFF; valid_a = 1'b1;
      data_b = '0; valid_b = 1'b0;
      data_c = '0; valid_c = 1'b0;
      data_d = '0; valid_d = 1'b0;
      #1;
      rst_n   = 1'b0;
      rst_n_d = 1'b0;

      // Reset held with valid asserted
      for (int i = 0; i < 5; i++) begin
         to_high();
         check("rst_ready", ready_a, 1'b0);
         check("rst_busy", busy_a, 1'b0);
         check("rst_pin_h", ddr_a, 2'b00);
         check("rst_pin_idle1", ddr_d, 1'b1);
         to_low();
         check("rst_pin_l", ddr_a, 2'b00);
      end
      rst_n   = 1'b1;
      rst_n_d = 1'b1;
      #1;
      check("rel_ready_pre", ready_a, 1'b0);
      to_high();
      check("rel_ready", ready_a, 1'b1);
      check("rel_valid_ignored", busy_a, 1'b0);
      valid_a = 1'b0;

      // Single word on two channels
      data_a  = {8'h3C, 8'hA5};
      valid_a = 1'b1;
      to_high();
      valid_a = 1'b0;
      check("sw_busy0", busy_a, 1'b1);
      for (int n = 1; n <= 6; n++) begin
         idx = (n >= 2 && n <= 5) ? 2 * (n - 2) : 0;
         to_high();
         check("sw_busy", busy_a, (n <= 3));
         check("sw_pin_h", ddr_a, (n >= 2 && n <= 5) ? {sw1[idx], sw0[idx]} : 2'b00);
         to_low();
         check("sw_pin_l", ddr_a, (n >= 2 && n <= 5) ? {sw1[idx+1], sw0[idx+1]} : 2'b00);
      end

      // Back-to-back words with valid held
      data_a  = {8'hF0, 8'h01};
      valid_a = 1'b1;
      check("b2b_ready_idle", ready_a, 1'b1);
      to_high();
      for (int n = 0; n <= 10; n++) begin
         if (n > 0) to_high();
         if (n == 0) data_a = {8'h0F, 8'h80};
         if (n == 4) valid_a = 1'b0;
         idx = (n >= 2 && n <= 9) ? 2 * (n - 2) : 0;
         check("b2b_ready", ready_a, bb_rdy[n]);
         check("b2b_pin_h", ddr_a, (n >= 2 && n <= 9) ? {bb1[idx], bb0[idx]} : 2'b00);
         to_low();
         check("b2b_pin_l", ddr_a, (n >= 2 && n <= 9) ? {bb1[idx+1], bb0[idx+1]} : 2'b00);
      end

      // MSB-first, SER_W=4
      data_b  = 4'b1000;
      valid_b = 1'b1;
      check("msb_ready", ready_b, 1'b1);
      to_high();
      valid_b = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         idx = (n >= 2 && n <= 3) ? 2 * (n - 2) : 0;
         to_high();
         check("msb_busy", busy_b, (n <= 1));
         check("msb_pin_h", ddr_b, (n >= 2 && n <= 3) ? ms[idx] : 1'b0);
         to_low();
         check("msb_pin_l", ddr_b, (n >= 2 && n <= 3) ? ms[idx+1] : 1'b0);
      end

      // SER_W=2, one word per clock
      data_c  = 2'b01;
      valid_c = 1'b1;
      check("w2_ready_idle", ready_c, 1'b1);
      to_high();
      for (int n = 0; n <= 5; n++) begin
         if (n > 0) to_high();
         if (n == 0) data_c = 2'b10;
         if (n == 1) data_c = 2'b11;
         if (n == 2) valid_c = 1'b0;
         idx = (n >= 2 && n <= 4) ? 2 * (n - 2) : 0;
         check("w2_ready", ready_c, 1'b1);
         check("w2_busy", busy_c, (n <= 2));
         check("w2_pin_h", ddr_c, (n >= 2 && n <= 4) ? w2[idx] : 1'b0);
         to_low();
         check("w2_pin_l", ddr_c, (n >= 2 && n <= 4) ? w2[idx+1] : 1'b0);
      end

      // Reset mid-word with IDLE=1, then a clean word
      data_d  = 8'h00;
      valid_d = 1'b1;
      check("rmw_ready", ready_d, 1'b1);
      to_high();
      valid_d = 1'b0;
      to_high();
      check("rmw_pin_idle", ddr_d, 1'b1);
      to_high();
      check("rmw_pin_h0", ddr_d, 1'b0);
      to_low();
      check("rmw_pin_l0", ddr_d, 1'b0);
      to_high();
      check("rmw_pin_h1", ddr_d, 1'b0);
      to_low();
      check("rmw_pin_l1", ddr_d, 1'b0);
      rst_n_d = 1'b0;
      #1;
      check("rmw_rst_pin", ddr_d, 1'b1);
      check("rmw_rst_busy", busy_d, 1'b0);
      check("rmw_rst_ready", ready_d, 1'b0);
      to_high();
      check("rmw_rst_pin_h", ddr_d, 1'b1);
      to_low();
      rst_n_d = 1'b1;
      to_high();
      check("rmw_rel_ready", ready_d, 1'b1);
      check("rmw_rel_busy", busy_d, 1'b0);
      data_d  = 8'h96;
      valid_d = 1'b1;
      to_high();
      valid_d = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         idx = (n >= 2 && n <= 5) ? 2 * (n - 2) : 0;
         to_high();
         check("rmw_new_h", ddr_d, (n >= 2 && n <= 5) ? rs[idx] : 1'b1);
         to_low();
         check("rmw_new_l", ddr_d, (n >= 2 && n <= 5) ? rs[idx+1] : 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
